// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package mem_arb_pkg;

  // RV funct3 for a full 32-bit access; DMA beats always use it.
  localparam logic [2:0] MEM_TYPE_WORD = 3'b010;

  localparam int DEF_MAX_CPU_RUN   = 4;
  localparam int DEF_MAX_DMA_BURST = 8;

  // Which requester owns the memory port this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Request/response bundle between the CPU M-stage, the DMA engine, the
// arbiter and the data memory. The arbiter takes the slave side; the
// environment (pipeline, DMA, memory) takes the master side.
interface dmem_port_arbiter_if;
  // CPU memory stage
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [2:0]  cpu_load_type;
  logic [2:0]  cpu_store_type;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  // DMA / loader
  logic        dma_req;
  logic        dma_we;
  logic        dma_last;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic [31:0] dma_rdata;
  // Data memory port
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_load_type;
  logic [2:0]  mem_store_type;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_load_type, cpu_store_type,
    input  dma_req, dma_we, dma_last, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_stall, cpu_rdata, dma_gnt, dma_rdata,
    output mem_we, mem_addr, mem_wdata, mem_load_type, mem_store_type
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_load_type, cpu_store_type,
    output dma_req, dma_we, dma_last, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_stall, cpu_rdata, dma_gnt, dma_rdata,
    input  mem_we, mem_addr, mem_wdata, mem_load_type, mem_store_type
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Single data-memory port shared by CPU M-stage and DMA, one access per
// cycle. Grant is combinational from registered fairness state; a starvation
// counter bounds DMA wait, a burst counter bounds CPU wait under a DMA lock.
module dmem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_CPU_RUN   = DEF_MAX_CPU_RUN,
  parameter int MAX_DMA_BURST = DEF_MAX_DMA_BURST
) (
  input  logic                clk,
  input  logic                rst,
  dmem_port_arbiter_if.slave  bus
);

  localparam int SW = $clog2(MAX_CPU_RUN + 1);
  localparam int BW = $clog2(MAX_DMA_BURST + 1);
  localparam logic [SW-1:0] RUN_MAX   = SW'(MAX_CPU_RUN);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DMA_BURST);

  logic [SW-1:0] starve_q, starve_d;
  logic [BW-1:0] burst_q,  burst_d;
  logic          lock_q,   lock_d;
  logic          force_cpu_q, force_cpu_d;

  owner_e own;
  logic   cpu_gnt, dma_gnt;

  // Grant decision, first match wins; a pending forced CPU beat pre-empts the lock.
  always_comb begin
    own = OWN_NONE;
    if (rst) begin
      own = OWN_NONE;
    end else if (lock_q && bus.dma_req) begin
      own = (force_cpu_q && bus.cpu_req) ? OWN_CPU : OWN_DMA;
    end else if (bus.dma_req && bus.cpu_req &&
                 (starve_q == RUN_MAX || (!force_cpu_q && lock_q))) begin
      own = OWN_DMA;
    end else if (bus.cpu_req) begin
      own = OWN_CPU;
    end else if (bus.dma_req) begin
      own = OWN_DMA;
    end
  end

  assign cpu_gnt = (own == OWN_CPU);
  assign dma_gnt = (own == OWN_DMA);

  // Port mux: owner drives the memory; idle keeps writes off and parks addr on the CPU.
  always_comb begin
    bus.mem_we         = 1'b0;
    bus.mem_addr       = bus.cpu_addr;
    bus.mem_wdata      = '0;
    bus.mem_load_type  = bus.cpu_load_type;
    bus.mem_store_type = bus.cpu_store_type;
    unique case (own)
      OWN_CPU: begin
        bus.mem_we    = bus.cpu_we;
        bus.mem_wdata = bus.cpu_wdata;
      end
      OWN_DMA: begin
        bus.mem_we         = bus.dma_we;
        bus.mem_addr       = bus.dma_addr;
        bus.mem_wdata      = bus.dma_wdata;
        bus.mem_load_type  = MEM_TYPE_WORD;
        bus.mem_store_type = MEM_TYPE_WORD;
      end
      default: ;
    endcase
  end

  assign bus.dma_gnt   = dma_gnt;
  assign bus.cpu_stall = bus.cpu_req && !cpu_gnt && !rst;
  // Read data is a fan-out; each side qualifies it with its own grant.
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.dma_rdata = bus.mem_rdata;

  // Fairness next-state: starvation run, burst lock/length and forced CPU beat.
  always_comb begin
    starve_d    = starve_q;
    lock_d      = lock_q;
    burst_d     = burst_q;
    force_cpu_d = force_cpu_q;

    if (dma_gnt || !bus.dma_req)
      starve_d = '0;
    else if (cpu_gnt && starve_q != RUN_MAX)
      starve_d = starve_q + 1'b1;

    if (dma_gnt) begin
      lock_d = !bus.dma_last;
      if (bus.dma_last)
        burst_d = '0;
      else if (burst_q != BURST_MAX)
        burst_d = burst_q + 1'b1;
    end else if (cpu_gnt) begin
      burst_d = '0;
    end

    // Lock survives the forced beat; only the burst length restarts.
    if (cpu_gnt)
      force_cpu_d = 1'b0;
    else if (burst_d == BURST_MAX && bus.cpu_req)
      force_cpu_d = 1'b1;
  end

  // State registers with synchronous reset; reset drops any burst lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q    <= '0;
      lock_q      <= 1'b0;
      burst_q     <= '0;
      force_cpu_q <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      lock_q      <= lock_d;
      burst_q     <= burst_d;
      force_cpu_q <= force_cpu_d;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural word memory.
module tb_dmem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_port_arbiter_if bus ();

  dmem_port_arbiter #(.MAX_CPU_RUN(4), .MAX_DMA_BURST(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 256-word memory, combinational read, write at the clock edge.
  logic [31:0] mem_arr [256];
  assign bus.mem_rdata = mem_arr[bus.mem_addr[9:2]];

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'hA500_0000 | 32'(i);
    forever begin
      @(posedge clk);
      if (bus.mem_we) mem_arr[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic idle_in();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.cpu_load_type = 3'b010; bus.cpu_store_type = 3'b010;
    bus.dma_req = 0; bus.dma_we = 0; bus.dma_last = 0;
    bus.dma_addr = '0; bus.dma_wdata = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  logic exp_dma;
  int   b;

  initial begin
    idle_in();
    // Reset with both requesters active: nothing granted, nothing written.
    bus.cpu_req = 1; bus.cpu_we = 1; bus.dma_req = 1; bus.dma_we = 1;
    @(negedge clk);
    chk("rst_dma_gnt", 32'(bus.dma_gnt), 32'd0);
    chk("rst_stall",   32'(bus.cpu_stall), 32'd0);
    chk("rst_mem_we",  32'(bus.mem_we), 32'd0);
    tick(); tick();
    rst = 0;
    idle_in();
    bus.cpu_addr = 32'h55;
    @(negedge clk);
    chk("idle_we",    32'(bus.mem_we), 32'd0);
    chk("idle_wdata", bus.mem_wdata, 32'd0);
    chk("idle_addr",  bus.mem_addr, 32'h55);
    chk("idle_gnt",   32'(bus.dma_gnt), 32'd0);
    tick();

    // CPU-only stores 0x10..0x34, then read them back.
    for (int i = 0; i < 10; i++) begin
      bus.cpu_req = 1; bus.cpu_we = 1;
      bus.cpu_addr = 32'h10 + 32'(4 * i); bus.cpu_wdata = 32'hC0DE_0000 + 32'(i);
      @(negedge clk);
      chk("st_stall",  32'(bus.cpu_stall), 32'd0);
      chk("st_mem_we", 32'(bus.mem_we), 32'd1);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      bus.cpu_we = 0; bus.cpu_addr = 32'h10 + 32'(4 * i);
      @(negedge clk);
      chk("ld_rdata",  bus.cpu_rdata, 32'hC0DE_0000 + 32'(i));
      chk("ld_mem_we", 32'(bus.mem_we), 32'd0);
      tick();
    end
    idle_in(); tick();

    // Both streaming, single-beat DMA: 4 CPU grants then 1 DMA, repeating.
    for (int i = 0; i < 10; i++) begin
      bus.cpu_req = 1; bus.cpu_addr = 32'h10;
      bus.dma_req = 1; bus.dma_last = 1; bus.dma_addr = 32'h200;
      exp_dma = (i % 5 == 4);
      @(negedge clk);
      chk("run_dma_gnt", 32'(bus.dma_gnt), 32'(exp_dma));
      chk("run_stall",   32'(bus.cpu_stall), 32'(exp_dma));
      tick();
    end
    idle_in(); tick();

    // 12-beat locked DMA read burst; CPU joins after beat 1 and gets one
    // forced beat after beat 8, then waits for the burst to finish.
    b = 1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      bus.dma_req  = (b <= 12);
      bus.dma_last = (b == 12);
      bus.dma_addr = 32'h200 + 32'(4 * (b - 1));
      bus.cpu_req  = (cyc >= 1);
      bus.cpu_addr = 32'h10; bus.cpu_load_type = 3'b000;
      exp_dma = (cyc != 8 && cyc != 13);
      @(negedge clk);
      chk($sformatf("bst_gnt%0d", cyc), 32'(bus.dma_gnt), 32'(exp_dma));
      chk($sformatf("bst_stall%0d", cyc), 32'(bus.cpu_stall), 32'(cyc >= 1 && exp_dma));
      if (exp_dma) begin
        chk("bst_rdata", bus.dma_rdata, 32'hA500_0080 + 32'(b - 1));
        chk("bst_ltype", 32'(bus.mem_load_type), 32'(MEM_TYPE_WORD));
      end else begin
        chk("bst_cpu_rdata", bus.cpu_rdata, 32'hC0DE_0000);
      end
      tick();
      if (exp_dma) b++;
    end
    idle_in(); tick();

    // CPU store then DMA read of the same word.
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 32'h40; bus.cpu_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("sw40_stall", 32'(bus.cpu_stall), 32'd0);
    tick();
    idle_in();
    bus.dma_req = 1; bus.dma_last = 1; bus.dma_addr = 32'h40; bus.cpu_load_type = 3'b100;
    @(negedge clk);
    chk("rd40_gnt",   32'(bus.dma_gnt), 32'd1);
    chk("rd40_rdata", bus.dma_rdata, 32'hDEAD_BEEF);
    chk("rd40_ltype", 32'(bus.mem_load_type), 32'b010);
    tick();
    idle_in(); tick();

    // Reset during beat 3 of a locked write burst.
    for (int i = 1; i <= 2; i++) begin
      bus.dma_req = 1; bus.dma_we = 1; bus.dma_last = 0;
      bus.dma_addr = 32'h300 + 32'(4 * (i - 1)); bus.dma_wdata = 32'h5A5A_0000 + 32'(i);
      @(negedge clk);
      chk("lk_gnt",    32'(bus.dma_gnt), 32'd1);
      chk("lk_mem_we", 32'(bus.mem_we), 32'd1);
      tick();
    end
    bus.dma_addr = 32'h308; bus.dma_wdata = 32'h5A5A_0003;
    rst = 1;
    @(negedge clk);
    chk("mid_rst_gnt",   32'(bus.dma_gnt), 32'd0);
    chk("mid_rst_we",    32'(bus.mem_we), 32'd0);
    chk("mid_rst_stall", 32'(bus.cpu_stall), 32'd0);
    tick();
    rst = 0;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h40;
    @(negedge clk);
    chk("post_rst_stall", 32'(bus.cpu_stall), 32'd0);
    chk("post_rst_gnt",   32'(bus.dma_gnt), 32'd0);
    chk("post_rst_rdata", bus.cpu_rdata, 32'hDEAD_BEEF);
    chk("beat1_mem",      mem_arr[8'hC0], 32'h5A5A_0001);
    chk("beat3_mem",      mem_arr[8'hC2], 32'hA500_00C2);
    tick();
    idle_in(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
